// File: rtl/ifq_pkg.sv
// Shared types and sizing helpers for the instruction fetch queue.
// Imported by the queue top and its line storage.
package ifq_pkg;

   typedef enum logic [1:0] {
      FETCH          = 2'd0,
      STALL          = 2'd1,
      REDIRECT_DRAIN = 2'd2
   } fetch_state_t;

   localparam int WORD_BYTES = 4;

   function automatic int off_width(input int wpl);
      return $clog2(wpl);
   endfunction

   function automatic int line_bytes(input int wpl);
      return wpl * WORD_BYTES;
   endfunction

endpackage

// File: rtl/ifq_line_fifo.sv
// Line storage for the fetch queue: write at tail, retire at head,
// single-cycle flush, occupancy count.
module ifq_line_fifo
   import ifq_pkg::*;
#(
   parameter int LINE_W = 128,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [LINE_W-1:0]          wr_line,
   input  logic                       retire,
   output logic [LINE_W-1:0]          head_line,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [LINE_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wptr;
   logic [PW-1:0]     rptr;
   logic [PW-1:0]     cnt;

   // line payload: no reset needed, qualified by count
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wptr[AW-1:0]] <= wr_line;
      end
   end

   // pointers and count; a write and a retire together leave count alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (wr_en) begin
            wptr <= wptr + PW'(1);
         end
         if (retire) begin
            rptr <= rptr + PW'(1);
         end
         cnt <= cnt + PW'(wr_en) - PW'(retire);
      end
   end

   assign head_line = mem[rptr[AW-1:0]];
   assign count     = cnt;
   assign full      = (cnt == PW'(DEPTH));

   // outstanding accounting must never deliver a line into a full queue
   a_no_write_when_full : assert property (
      @(posedge clk) disable iff (rst) !(wr_en && full)
   );

endmodule

// File: rtl/ifq_param.sv
// Parametrised instruction fetch queue: line requests, buffering,
// per-word dispatch with empty-queue bypass, redirect and drain.
module ifq_param
   import ifq_pkg::*;
#(
   parameter int              XLEN           = 32,
   parameter int              WORDS_PER_LINE = 4,
   parameter int              DEPTH          = 4,
   parameter logic [XLEN-1:0] RESET_PC       = '0
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [XLEN*WORDS_PER_LINE-1:0] i_line,
   input  logic                           i_line_valid,
   input  logic                           i_rd_en,
   input  logic [XLEN-1:0]                i_redirect_addr,
   input  logic                           i_redirect_valid,
   output logic [XLEN-1:0]                o_fetch_addr,
   output logic                           o_fetch_req,
   output logic                           o_abort,
   output logic [XLEN-1:0]                o_pc,
   output logic [XLEN-1:0]                o_instr,
   output logic                           o_empty,
   output logic                           o_full
);

   localparam int OFFW  = off_width(WORDS_PER_LINE);
   localparam int LB    = line_bytes(WORDS_PER_LINE);
   localparam int LINEW = XLEN * WORDS_PER_LINE;
   localparam int PW    = $clog2(DEPTH) + 1;
   localparam logic [XLEN-1:0] LINE_MASK = ~XLEN'(LB - 1);
   localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

   fetch_state_t     state;
   fetch_state_t     state_nxt;
   logic [XLEN-1:0]  fetch_addr;
   logic [XLEN-1:0]  pc;
   logic [OFFW-1:0]  offset;
   logic [PW-1:0]    outstanding;
   logic [PW-1:0]    out_nxt;
   logic [PW-1:0]    count;
   logic [PW-1:0]    cnt_nxt;
   logic [PW:0]      total;
   logic [PW:0]      total_nxt;
   logic [LINEW-1:0] head_line;
   logic [LINEW-1:0] src_line;
   logic [XLEN-1:0]  word;
   logic             full;
   logic             line_ok;
   logic             accept;
   logic             bypass;
   logic             avail;
   logic             req;
   logic             fire;
   logic             retire;
   logic             abort_q;

   ifq_line_fifo #(
      .LINE_W (LINEW),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .flush     (i_redirect_valid),
      .wr_en     (accept),
      .wr_line   (i_line),
      .retire    (retire),
      .head_line (head_line),
      .count     (count),
      .full      (full)
   );

   // datapath: line acceptance, bypass word select, issue and dispatch
   always_comb begin
      line_ok   = i_line_valid && (outstanding != '0);
      accept    = line_ok && !i_redirect_valid &&
                  (state != REDIRECT_DRAIN);
      bypass    = accept && (count == '0);
      avail     = (count != '0) || bypass;
      src_line  = bypass ? i_line : head_line;
      word      = src_line[int'(offset)*XLEN +: XLEN];
      total     = {1'b0, count} + {1'b0, outstanding};
      req       = !i_rst && !i_redirect_valid && (state == FETCH) &&
                  (total < (PW+1)'(DEPTH));
      fire      = i_rd_en && avail && !i_redirect_valid;
      retire    = fire && (offset == OFFW'(WORDS_PER_LINE - 1));
      out_nxt   = outstanding + PW'(req) - PW'(line_ok);
      cnt_nxt   = i_redirect_valid ? '0 :
                  count + PW'(accept) - PW'(retire);
      total_nxt = {1'b0, cnt_nxt} + {1'b0, out_nxt};
   end

   // fetch FSM next state; redirect overrides everything
   always_comb begin
      state_nxt = state;
      if (i_redirect_valid) begin
         state_nxt = (out_nxt != '0) ? REDIRECT_DRAIN : FETCH;
      end else begin
         unique case (state)
            FETCH: begin
               if (total_nxt >= (PW+1)'(DEPTH)) state_nxt = STALL;
            end
            STALL: begin
               if (retire) state_nxt = FETCH;
            end
            REDIRECT_DRAIN: begin
               if (out_nxt == '0) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
         endcase
      end
   end

   // state, request address, PC and word offset registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= FETCH;
         fetch_addr  <= RESET_PC;
         pc          <= RESET_PC;
         offset      <= '0;
         outstanding <= '0;
         abort_q     <= 1'b0;
      end else begin
         state       <= state_nxt;
         outstanding <= out_nxt;
         abort_q     <= i_redirect_valid;
         if (i_redirect_valid) begin
            fetch_addr <= i_redirect_addr & LINE_MASK;
            pc         <= i_redirect_addr & WORD_MASK;
            offset     <= i_redirect_addr[OFFW+1:2];
         end else begin
            if (req) begin
               fetch_addr <= fetch_addr + XLEN'(LB);
            end
            if (fire) begin
               pc     <= pc + XLEN'(4);
               offset <= offset + OFFW'(1);
            end
         end
      end
   end

   assign o_fetch_addr = fetch_addr;
   assign o_fetch_req  = req;
   assign o_abort      = abort_q;
   assign o_pc         = pc;
   assign o_instr      = avail ? word : '0;
   assign o_empty      = !avail;
   assign o_full       = full;

endmodule

// File: tb/tb_ifq_param.sv
// Directed bench for ifq_param: table-driven fill/stall/retire vectors
// plus hand sequences for streaming, redirect, wrap and reset.
module tb_ifq_param;

   logic         clk = 1'b0;
   logic         i_rst = 1'b1;
   logic [127:0] i_line = '0;
   logic         i_line_valid = 1'b0;
   logic         i_rd_en = 1'b0;
   logic [31:0]  i_redirect_addr = '0;
   logic         i_redirect_valid = 1'b0;
   logic [31:0]  o_fetch_addr;
   logic         o_fetch_req;
   logic         o_abort;
   logic [31:0]  o_pc;
   logic [31:0]  o_instr;
   logic         o_empty;
   logic         o_full;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int lat = 1;
   logic cur_lv = 1'b0;

   typedef struct {
      logic [31:0] a;
      int          due;
   } mreq_t;
   mreq_t mq[$];

   typedef struct {
      logic        lv;
      logic [31:0] la;
      logic        rd;
      logic        req;
      logic [31:0] fa;
      logic        emp;
      logic        full;
      logic [31:0] pc;
      logic [31:0] ins;
   } vec_t;
   vec_t tv[12];

   ifq_param dut (
      .i_clk            (clk),
      .i_rst            (i_rst),
      .i_line           (i_line),
      .i_line_valid     (i_line_valid),
      .i_rd_en          (i_rd_en),
      .i_redirect_addr  (i_redirect_addr),
      .i_redirect_valid (i_redirect_valid),
      .o_fetch_addr     (o_fetch_addr),
      .o_fetch_req      (o_fetch_req),
      .o_abort          (o_abort),
      .o_pc             (o_pc),
      .o_instr          (o_instr),
      .o_empty          (o_empty),
      .o_full           (o_full)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ins_of(input logic [31:0] a);
      return a + 32'h1000_0000;
   endfunction

   function automatic logic [127:0] mk_line(input logic [31:0] a);
      logic [127:0] l;
      for (int k = 0; k < 4; k++) begin
         l[k*32 +: 32] = ins_of(a + 32'(4 * k));
      end
      return l;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_line_valid = 1'b0;
      i_line = '0;
      i_rd_en = 1'b0;
      i_redirect_valid = 1'b0;
      i_redirect_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      i_rst = 1'b0;
      mq.delete();
      cyc = 0;
   endtask

   task automatic step(input logic lv, input logic [31:0] la,
                       input logic rd, input logic rv,
                       input logic [31:0] ra);
      @(negedge clk);
      i_line_valid = lv;
      i_line = lv ? mk_line(la) : '0;
      i_rd_en = rd;
      i_redirect_valid = rv;
      i_redirect_addr = ra;
      cur_lv = lv;
      #1;
   endtask

   task automatic mem_cycle(input logic rd, input logic rv,
                            input logic [31:0] ra);
      logic        lv;
      logic [31:0] la;
      lv = 1'b0;
      la = '0;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
         lv = 1'b1;
         la = mq[0].a;
         void'(mq.pop_front());
      end
      step(lv, la, rd, rv, ra);
      if (o_fetch_req) mq.push_back('{a: o_fetch_addr, due: cyc + lat});
      cyc++;
   endtask

   initial begin
      int          nreq;
      logic        seen;
      logic [31:0] exp_pc;

      // fill to full with immediate returns, then drain one line
      tv[0]  = '{0, 32'h00, 0, 1, 32'h00, 1, 0, 32'h00, 32'h0};
      tv[1]  = '{1, 32'h00, 0, 1, 32'h10, 0, 0, 32'h00, 32'h1000_0000};
      tv[2]  = '{1, 32'h10, 0, 1, 32'h20, 0, 0, 32'h00, 32'h1000_0000};
      tv[3]  = '{1, 32'h20, 0, 1, 32'h30, 0, 0, 32'h00, 32'h1000_0000};
      tv[4]  = '{1, 32'h30, 0, 0, 32'h40, 0, 0, 32'h00, 32'h1000_0000};
      tv[5]  = '{0, 32'h00, 0, 0, 32'h40, 0, 1, 32'h00, 32'h1000_0000};
      tv[6]  = '{0, 32'h00, 1, 0, 32'h40, 0, 1, 32'h00, 32'h1000_0000};
      tv[7]  = '{0, 32'h00, 1, 0, 32'h40, 0, 1, 32'h04, 32'h1000_0004};
      tv[8]  = '{0, 32'h00, 1, 0, 32'h40, 0, 1, 32'h08, 32'h1000_0008};
      tv[9]  = '{0, 32'h00, 1, 0, 32'h40, 0, 1, 32'h0C, 32'h1000_000C};
      tv[10] = '{0, 32'h00, 0, 1, 32'h40, 0, 0, 32'h10, 32'h1000_0010};
      tv[11] = '{0, 32'h00, 0, 0, 32'h50, 0, 0, 32'h10, 32'h1000_0010};

      // reset values while reset is held
      #2;
      chk("rst fetch_addr", o_fetch_addr, 32'h0);
      chk("rst pc", o_pc, 32'h0);
      chk("rst req", o_fetch_req, 1'b0);
      chk("rst abort", o_abort, 1'b0);
      chk("rst instr", o_instr, 32'h0);
      chk("rst empty", o_empty, 1'b1);
      chk("rst full", o_full, 1'b0);

      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(tv[i].lv, tv[i].la, tv[i].rd, 1'b0, 32'h0);
         chk($sformatf("tab[%0d] req", i), o_fetch_req, tv[i].req);
         chk($sformatf("tab[%0d] faddr", i), o_fetch_addr, tv[i].fa);
         chk($sformatf("tab[%0d] empty", i), o_empty, tv[i].emp);
         chk($sformatf("tab[%0d] full", i), o_full, tv[i].full);
         chk($sformatf("tab[%0d] pc", i), o_pc, tv[i].pc);
         chk($sformatf("tab[%0d] instr", i), o_instr, tv[i].ins);
         chk($sformatf("tab[%0d] abort", i), o_abort, 1'b0);
      end

      // streaming with 2-cycle memory latency, always reading
      do_reset();
      lat = 2;
      nreq = 0;
      seen = 1'b0;
      exp_pc = 32'h0;
      for (int c = 0; c < 30; c++) begin
         mem_cycle(1'b1, 1'b0, 32'h0);
         if (o_fetch_req) begin
            chk($sformatf("stream req%0d addr", nreq), o_fetch_addr,
                32'(nreq * 16));
            nreq++;
         end
         if (c == 2) chk("stream first line arrives", cur_lv, 1'b1);
         if (cur_lv) seen = 1'b1;
         if (!seen) begin
            chk($sformatf("stream c%0d empty", c), o_empty, 1'b1);
         end else begin
            chk($sformatf("stream c%0d empty", c), o_empty, 1'b0);
            chk($sformatf("stream c%0d pc", c), o_pc, exp_pc);
            chk($sformatf("stream c%0d instr", c), o_instr, ins_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end
      end
      chk("stream enough requests", 32'(nreq >= 3), 32'h1);

      // redirect with two requests in flight
      do_reset();
      lat = 3;
      mem_cycle(1'b0, 1'b0, 32'h0);
      chk("redir c0 req", o_fetch_req, 1'b1);
      mem_cycle(1'b0, 1'b0, 32'h0);
      chk("redir c1 faddr", o_fetch_addr, 32'h10);
      mem_cycle(1'b0, 1'b1, 32'h1238);
      chk("redir c2 abort", o_abort, 1'b0);
      mem_cycle(1'b1, 1'b0, 32'h0);
      chk("redir c3 stale line", cur_lv, 1'b1);
      chk("redir c3 abort", o_abort, 1'b1);
      chk("redir c3 empty", o_empty, 1'b1);
      chk("redir c3 pc", o_pc, 32'h1238);
      chk("redir c3 req", o_fetch_req, 1'b0);
      mem_cycle(1'b1, 1'b0, 32'h0);
      chk("redir c4 abort", o_abort, 1'b0);
      chk("redir c4 empty", o_empty, 1'b1);
      chk("redir c4 req", o_fetch_req, 1'b0);
      mem_cycle(1'b1, 1'b0, 32'h0);
      chk("redir c5 req", o_fetch_req, 1'b1);
      chk("redir c5 faddr", o_fetch_addr, 32'h1230);
      mem_cycle(1'b1, 1'b0, 32'h0);
      chk("redir c6 empty", o_empty, 1'b1);
      mem_cycle(1'b1, 1'b0, 32'h0);
      chk("redir c7 empty", o_empty, 1'b1);
      mem_cycle(1'b1, 1'b0, 32'h0);
      chk("redir c8 empty", o_empty, 1'b0);
      chk("redir c8 pc", o_pc, 32'h1238);
      chk("redir c8 instr", o_instr, 32'h1000_1238);
      mem_cycle(1'b1, 1'b0, 32'h0);
      chk("redir c9 pc", o_pc, 32'h123C);
      chk("redir c9 instr", o_instr, 32'h1000_123C);
      mem_cycle(1'b1, 1'b0, 32'h0);
      chk("redir c10 pc", o_pc, 32'h1240);
      chk("redir c10 instr", o_instr, 32'h1000_1240);

      // redirect, line arrival and read in one cycle
      do_reset();
      lat = 1;
      mem_cycle(1'b0, 1'b0, 32'h0);
      chk("same c0 req", o_fetch_req, 1'b1);
      mem_cycle(1'b1, 1'b1, 32'h2000);
      chk("same c1 line", cur_lv, 1'b1);
      chk("same c1 empty", o_empty, 1'b1);
      chk("same c1 instr", o_instr, 32'h0);
      chk("same c1 pc", o_pc, 32'h0);
      mem_cycle(1'b0, 1'b0, 32'h0);
      chk("same c2 pc", o_pc, 32'h2000);
      chk("same c2 empty", o_empty, 1'b1);
      chk("same c2 full", o_full, 1'b0);
      chk("same c2 abort", o_abort, 1'b1);
      chk("same c2 req", o_fetch_req, 1'b1);
      chk("same c2 faddr", o_fetch_addr, 32'h2000);
      mem_cycle(1'b0, 1'b0, 32'h0);
      chk("same c3 empty", o_empty, 1'b0);
      chk("same c3 pc", o_pc, 32'h2000);
      chk("same c3 instr", o_instr, 32'h1000_2000);

      // address wrap at the top of the space
      do_reset();
      lat = 1;
      mem_cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
      chk("wrap c0 req", o_fetch_req, 1'b0);
      mem_cycle(1'b1, 1'b0, 32'h0);
      chk("wrap c1 req", o_fetch_req, 1'b1);
      chk("wrap c1 faddr", o_fetch_addr, 32'hFFFF_FFF0);
      chk("wrap c1 pc", o_pc, 32'hFFFF_FFF8);
      chk("wrap c1 empty", o_empty, 1'b1);
      mem_cycle(1'b1, 1'b0, 32'h0);
      chk("wrap c2 faddr", o_fetch_addr, 32'h0);
      chk("wrap c2 req", o_fetch_req, 1'b1);
      chk("wrap c2 empty", o_empty, 1'b0);
      chk("wrap c2 instr", o_instr, 32'h0FFF_FFF8);
      mem_cycle(1'b1, 1'b0, 32'h0);
      chk("wrap c3 pc", o_pc, 32'hFFFF_FFFC);
      chk("wrap c3 instr", o_instr, 32'h0FFF_FFFC);
      mem_cycle(1'b1, 1'b0, 32'h0);
      chk("wrap c4 pc", o_pc, 32'h0);
      chk("wrap c4 instr", o_instr, 32'h1000_0000);

      // asynchronous reset with three lines stored
      do_reset();
      lat = 1;
      for (int c = 0; c < 5; c++) mem_cycle(1'b0, 1'b0, 32'h0);
      chk("mid pre empty", o_empty, 1'b0);
      chk("mid pre faddr", o_fetch_addr, 32'h40);
      chk("mid pre req", o_fetch_req, 1'b0);
      #1;
      i_rst = 1'b1;
      #1;
      chk("mid rst faddr", o_fetch_addr, 32'h0);
      chk("mid rst pc", o_pc, 32'h0);
      chk("mid rst req", o_fetch_req, 1'b0);
      chk("mid rst abort", o_abort, 1'b0);
      chk("mid rst instr", o_instr, 32'h0);
      chk("mid rst empty", o_empty, 1'b1);
      chk("mid rst full", o_full, 1'b0);
      do_reset();
      step(1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
      chk("post rst unsolicited empty", o_empty, 1'b1);
      chk("post rst req", o_fetch_req, 1'b1);
      chk("post rst faddr", o_fetch_addr, 32'h0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("post rst next faddr", o_fetch_addr, 32'h10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
